// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl
//   Iterative AES-128 encryption sequencer. Applies the initial AddRoundKey
//   on accept, then steps an external single-round datapath once per clock
//   for NR rounds, fetching each round key from an external key schedule.
//
// Ports
//   clk_i, rst_i            clock (rising edge), async active-high reset
//   abort_i                 synchronous abort, drops the block in flight
//   in_valid_i/in_ready_o   plaintext/key handshake (pt_i, key_i)
//   out_valid_o/out_ready_i ciphertext handshake (ct_o)
//   busy_o                  high while rounds are being computed
//   ks_key_o, ks_round_o    cipher key and round index to the key schedule
//   ks_rkey_i               round key for ks_round_o (same cycle)
//   rf_data_o, rf_key_o     state and round key to the round datapath
//   rf_last_o               final round, datapath skips MixColumns
//   rf_data_i               round datapath result (same cycle)
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | waiting for a block, in_ready_o high
// S_ROUND  | one round per cycle, rnd_q = 1..NR
// S_DONE   | ciphertext held on ct_o until out_ready_i
module aes_round_ctrl #(
    parameter int WIDTH = 128,
    parameter int NR    = 10,
    parameter int RW    = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             abort_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] pt_i,
    input  logic [WIDTH-1:0] key_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] ct_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] ks_key_o,
    output logic [RW-1:0]    ks_round_o,
    input  logic [WIDTH-1:0] ks_rkey_i,
    output logic [WIDTH-1:0] rf_data_o,
    output logic [WIDTH-1:0] rf_key_o,
    output logic             rf_last_o,
    input  logic [WIDTH-1:0] rf_data_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } fsm_e;

    localparam logic [RW-1:0] RND_FIRST = RW'(1);
    localparam logic [RW-1:0] RND_LAST  = RW'(NR);

    fsm_e             fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] key_q, key_d;
    logic [RW-1:0]    rnd_q, rnd_d;
    logic             accept;

    // in_ready_o is held low during reset even though the FSM already sits
    // in S_IDLE, so nothing can be handed over while the block is in reset.
    assign in_ready_o  = ~rst_i & ((fsm_q == S_IDLE) | ((fsm_q == S_DONE) & out_ready_i));
    assign accept      = in_valid_i & in_ready_o;

    assign busy_o      = (fsm_q == S_ROUND);
    assign out_valid_o = (fsm_q == S_DONE);
    assign ct_o        = out_valid_o ? state_q : '0;
    assign ks_key_o    = key_q;
    assign ks_round_o  = busy_o ? rnd_q : '0;
    assign rf_data_o   = state_q;
    assign rf_key_o    = ks_rkey_i;
    assign rf_last_o   = busy_o & (rnd_q == RND_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm_q   <= S_IDLE;
            state_q <= '0;
            key_q   <= '0;
            rnd_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        rnd_d   = rnd_q;

        // Abort wins over everything, including a coincident accept; the
        // datapath result is not taken so state/key keep their old values.
        if (abort_i) begin
            fsm_d = S_IDLE;
            rnd_d = '0;
        end else begin
            unique case (fsm_q)
                S_IDLE: begin
                    if (accept) begin
                        state_d = pt_i ^ key_i;
                        key_d   = key_i;
                        rnd_d   = RND_FIRST;
                        fsm_d   = S_ROUND;
                    end
                end
                S_ROUND: begin
                    state_d = rf_data_i;
                    if (rnd_q == RND_LAST) begin
                        fsm_d = S_DONE;
                        rnd_d = '0;
                    end else begin
                        rnd_d = rnd_q + RND_FIRST;
                    end
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        if (accept) begin
                            state_d = pt_i ^ key_i;
                            key_d   = key_i;
                            rnd_d   = RND_FIRST;
                            fsm_d   = S_ROUND;
                        end else begin
                            fsm_d = S_IDLE;
                        end
                    end
                end
                default: begin
                    fsm_d = S_IDLE;
                    rnd_d = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
module tb_aes_round_ctrl;

    localparam int WIDTH = 128;
    localparam int NR    = 10;
    localparam int RW    = 4;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             abort_i = 1'b0;
    logic             in_valid_i = 1'b0;
    logic             in_ready_o;
    logic [WIDTH-1:0] pt_i = '0;
    logic [WIDTH-1:0] key_i = '0;
    logic             out_valid_o;
    logic             out_ready_i = 1'b0;
    logic [WIDTH-1:0] ct_o;
    logic             busy_o;
    logic [WIDTH-1:0] ks_key_o;
    logic [RW-1:0]    ks_round_o;
    logic [WIDTH-1:0] ks_rkey_i;
    logic [WIDTH-1:0] rf_data_o;
    logic [WIDTH-1:0] rf_key_o;
    logic             rf_last_o;
    logic [WIDTH-1:0] rf_data_i;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    aes_round_ctrl #(.WIDTH(WIDTH), .NR(NR), .RW(RW)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .abort_i    (abort_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .pt_i       (pt_i),
        .key_i      (key_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .ct_o       (ct_o),
        .busy_o     (busy_o),
        .ks_key_o   (ks_key_o),
        .ks_round_o (ks_round_o),
        .ks_rkey_i  (ks_rkey_i),
        .rf_data_o  (rf_data_o),
        .rf_key_o   (rf_key_o),
        .rf_last_o  (rf_last_o),
        .rf_data_i  (rf_data_i)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // ---------------- AES reference datapath and key schedule ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // x^254 = x^2 * x^4 * ... * x^128 gives the GF(2^8) inverse (0 -> 0)
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r+4*c] = b[r+4*((c+r)%4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i] ^ k[127-8*i -: 8];
        return o;
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] key, input logic [RW-1:0] r);
        logic [31:0] w0, w1, w2, w3, tmp;
        logic [7:0]  rc;
        {w0, w1, w2, w3} = key;
        rc = 8'h01;
        for (int i = 1; i <= int'(r); i++) begin
            tmp = {w3[23:0], w3[31:24]};
            tmp = {sbox(tmp[31:24]), sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])} ^ {rc, 24'h0};
            w0 = w0 ^ tmp;
            w1 = w1 ^ w0;
            w2 = w2 ^ w1;
            w3 = w3 ^ w2;
            rc = xt(rc);
        end
        return {w0, w1, w2, w3};
    endfunction

    always_comb ks_rkey_i = round_key(ks_key_o, ks_round_o);
    always_comb rf_data_i = aes_round(rf_data_o, rf_key_o, rf_last_o);

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic accept(input logic [127:0] pt, input logic [127:0] key, input logic rdy,
                          input string nm);
        in_valid_i  = 1'b1;
        pt_i        = pt;
        key_i       = key;
        out_ready_i = rdy;
        settle();
        chk({nm, " in_ready"}, 128'(in_ready_o), 128'(1));
        tick();
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        settle();
    endtask

    // Called just after the accept edge; returns in DONE with out_ready_i low.
    task automatic wait_done(input logic [127:0] r0, input logic [127:0] exp, input string nm,
                             output int lat);
        int nb;
        lat = 1;
        nb  = 0;
        while (!out_valid_o && lat < 40) begin
            if (busy_o) begin
                nb++;
                if (nb == 1) chk({nm, " round0 state"}, rf_data_o, r0);
                chk({nm, " ks_round"}, 128'(ks_round_o), 128'(nb));
                chk({nm, " rf_last"}, 128'(rf_last_o), 128'(nb == NR));
            end
            tick();
            lat++;
        end
        chk({nm, " latency"}, 128'(lat), 128'(NR + 1));
        chk({nm, " busy cycles"}, 128'(nb), 128'(NR));
        chk({nm, " ct"}, ct_o, exp);
    endtask

    task automatic release_out(input string nm);
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        settle();
        tick();
        out_ready_i = 1'b0;
        settle();
        chk({nm, " out_valid after release"}, 128'(out_valid_o), 128'(0));
        chk({nm, " idle in_ready"}, 128'(in_ready_o), 128'(1));
    endtask

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] r0;
        logic [127:0] ct;
    } vec_t;

    vec_t vecs [3];

    initial begin
        int lat;
        int t1;
        int t2;
        int seen;
        int found;

        // FIPS-197 C.1, FIPS-197 Appendix B, all-zero key/plaintext
        vecs[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                    128'h00102030405060708090a0b0c0d0e0f0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'h3925841d02dc09fbdc118597196a0b32};
        vecs[2] = '{128'h0, 128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

        // reset values
        #2;
        chk("rst in_ready", 128'(in_ready_o), 128'(0));
        chk("rst out_valid", 128'(out_valid_o), 128'(0));
        chk("rst busy", 128'(busy_o), 128'(0));
        chk("rst ct", ct_o, 128'h0);
        chk("rst ks_round", 128'(ks_round_o), 128'(0));
        chk("rst rf_last", 128'(rf_last_o), 128'(0));
        chk("rst ks_key", ks_key_o, 128'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();
        chk("post-rst in_ready", 128'(in_ready_o), 128'(1));

        // table-driven blocks
        for (int i = 0; i < 3; i++) begin
            accept(vecs[i].pt, vecs[i].key, 1'b0, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d ks_key", i), ks_key_o, vecs[i].key);
            wait_done(vecs[i].r0, vecs[i].ct, $sformatf("vec%0d", i), lat);
            release_out($sformatf("vec%0d", i));
        end

        // backpressure: ct held, in_valid ignored
        accept(vecs[0].pt, vecs[0].key, 1'b0, "bp");
        wait_done(vecs[0].r0, vecs[0].ct, "bp", lat);
        in_valid_i = 1'b1;
        pt_i       = vecs[1].pt;
        key_i      = vecs[1].key;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("bp ct stable", ct_o, vecs[0].ct);
            chk("bp in_ready low", 128'(in_ready_o), 128'(0));
            chk("bp out_valid", 128'(out_valid_o), 128'(1));
            chk("bp not busy", 128'(busy_o), 128'(0));
            tick();
        end
        chk("bp key unchanged", ks_key_o, vecs[0].key);
        release_out("bp");

        // back-to-back: second block accepted in the DONE cycle
        accept(vecs[0].pt, vecs[0].key, 1'b0, "b2b a");
        wait_done(vecs[0].r0, vecs[0].ct, "b2b a", lat);
        t1 = cyc;
        accept(vecs[1].pt, vecs[1].key, 1'b1, "b2b b");
        chk("b2b b busy", 128'(busy_o), 128'(1));
        wait_done(vecs[1].r0, vecs[1].ct, "b2b b", lat);
        t2 = cyc;
        chk("b2b spacing", 128'(t2 - t1), 128'(NR + 1));
        release_out("b2b");

        // abort at rnd 4
        accept(vecs[0].pt, vecs[0].key, 1'b0, "abort");
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            if (ks_round_o == 4'd4) found = 1;
            else tick();
        end
        chk("abort reached rnd4", 128'(found), 128'(1));
        abort_i = 1'b1;
        settle();
        tick();
        abort_i = 1'b0;
        settle();
        chk("abort busy", 128'(busy_o), 128'(0));
        chk("abort out_valid", 128'(out_valid_o), 128'(0));
        chk("abort in_ready", 128'(in_ready_o), 128'(1));
        chk("abort ks_round", 128'(ks_round_o), 128'(0));
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            if (out_valid_o || busy_o) seen++;
            tick();
        end
        chk("abort stays idle", 128'(seen), 128'(0));
        accept(vecs[1].pt, vecs[1].key, 1'b0, "post-abort");
        wait_done(vecs[1].r0, vecs[1].ct, "post-abort", lat);

        // abort in DONE overrides a coincident accept
        in_valid_i  = 1'b1;
        pt_i        = vecs[2].pt;
        key_i       = vecs[2].key;
        out_ready_i = 1'b1;
        abort_i     = 1'b1;
        settle();
        tick();
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        abort_i     = 1'b0;
        settle();
        chk("done-abort busy", 128'(busy_o), 128'(0));
        chk("done-abort out_valid", 128'(out_valid_o), 128'(0));
        chk("done-abort key kept", ks_key_o, vecs[1].key);

        // async reset mid-ROUND
        accept(vecs[0].pt, vecs[0].key, 1'b0, "rst");
        tick();
        tick();
        #2;
        rst_i = 1'b1;
        #1;
        chk("mid rst busy", 128'(busy_o), 128'(0));
        chk("mid rst out_valid", 128'(out_valid_o), 128'(0));
        chk("mid rst in_ready", 128'(in_ready_o), 128'(0));
        chk("mid rst ks_round", 128'(ks_round_o), 128'(0));
        chk("mid rst ct", ct_o, 128'h0);
        chk("mid rst ks_key", ks_key_o, 128'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        settle();
        chk("after rst in_ready", 128'(in_ready_o), 128'(1));
        tick();
        accept(vecs[2].pt, vecs[2].key, 1'b0, "post-rst");
        wait_done(vecs[2].r0, vecs[2].ct, "post-rst", lat);
        release_out("post-rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
